// File: rtl/reg_file_ctrl.sv
// Sequencer that drives an 8-register, 8-bit reg_file.
// Each instruction is read, executed and written back through the reg_file ports.
module reg_file_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  input  logic [7:0]  REGOUT1,
  input  logic [7:0]  REGOUT2,
  output logic [2:0]  READREG1,
  output logic [2:0]  READREG2,
  output logic [2:0]  WRITEREG,
  output logic [7:0]  WRITEDATA,
  output logic        WRITEENABLE,
  output logic        DONE,
  output logic        ERROR
);

  typedef enum logic [1:0] {
    IDLE, READ, EXEC, WRITE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic [2:0] dst_q, dst_d;
  logic [2:0] rr1_q, rr1_d;
  logic [2:0] rr2_q, rr2_d;
  logic [2:0] wreg_q, wreg_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       ready_q, ready_d;
  logic [7:0] alu;
  logic       is_loadi, is_regop;

  // Bits outside the instruction fields carry no meaning.
  logic unused_instr;
  assign unused_instr = ^{INSTR[23:19], INSTR[15:11]};

  assign is_loadi = (INSTR[31:24] == 8'h00);
  assign is_regop = (INSTR[31:24] >= 8'h01) &&
                    (INSTR[31:24] <= 8'h05);

  always_comb begin
    unique case (op_q)
      8'h01:   alu = REGOUT2;
      8'h02:   alu = REGOUT1 + REGOUT2;
      8'h03:   alu = REGOUT1 - REGOUT2;
      8'h04:   alu = REGOUT1 & REGOUT2;
      8'h05:   alu = REGOUT1 | REGOUT2;
      default: alu = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    rr1_d   = rr1_q;
    rr2_d   = rr2_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ready_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (INSTR_VALID) begin
          unique case (1'b1)
            is_loadi: begin
              op_d    = INSTR[31:24];
              dst_d   = INSTR[18:16];
              wreg_d  = INSTR[18:16];
              wdata_d = INSTR[7:0];
              we_d    = 1'b1;
              done_d  = 1'b1;
              ready_d = 1'b0;
              state_d = WRITE;
            end
            is_regop: begin
              op_d    = INSTR[31:24];
              dst_d   = INSTR[18:16];
              rr1_d   = INSTR[10:8];
              rr2_d   = INSTR[2:0];
              ready_d = 1'b0;
              state_d = READ;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      READ: state_d = EXEC;
      EXEC: begin
        // REGOUT is valid here because the addresses were held a full cycle.
        wreg_d  = dst_q;
        wdata_d = alu;
        we_d    = 1'b1;
        done_d  = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      op_q    <= 8'h00;
      dst_q   <= 3'd0;
      rr1_q   <= 3'd0;
      rr2_q   <= 3'd0;
      wreg_q  <= 3'd0;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      rr1_q   <= rr1_d;
      rr2_q   <= rr2_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign INSTR_READY = ready_q;
  assign READREG1    = rr1_q;
  assign READREG2    = rr2_q;
  assign WRITEREG    = wreg_q;
  assign WRITEDATA   = wdata_q;
  assign WRITEENABLE = we_q;
  assign DONE        = done_q;
  assign ERROR       = err_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Bench for reg_file_ctrl with a behavioural reg_file and
// an instruction-level reference model.
module tb_reg_file_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [7:0]  REGOUT1, REGOUT2;
  logic [2:0]  READREG1, READREG2, WRITEREG;
  logic [7:0]  WRITEDATA;
  logic        WRITEENABLE, DONE, ERROR;

  int tests = 0;
  int fails = 0;

  reg_file_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY),
    .REGOUT1(REGOUT1), .REGOUT2(REGOUT2),
    .READREG1(READREG1), .READREG2(READREG2),
    .WRITEREG(WRITEREG), .WRITEDATA(WRITEDATA),
    .WRITEENABLE(WRITEENABLE), .DONE(DONE),
    .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  // Behavioural reg_file the DUT talks to.
  logic [7:0] rf [8];
  assign REGOUT1 = rf[READREG1];
  assign REGOUT2 = rf[READREG2];
  always @(posedge CLK)
    if (WRITEENABLE) rf[WRITEREG] <= WRITEDATA;

  // Architectural register contents as the model sees them.
  logic [7:0] mdl [8];

  typedef struct packed {
    logic       err;
    logic [3:0] lat;
    logic [2:0] rr1;
    logic [2:0] rr2;
    logic [2:0] wreg;
    logic [7:0] wdata;
    logic       done;
    logic       rdy;
    logic       we_after;
  } obs_t;

  function automatic obs_t model(input logic [31:0] ins);
    obs_t e;
    logic [7:0] a, b, r;
    e = '0;
    a = mdl[ins[10:8]];
    b = mdl[ins[2:0]];
    case (ins[31:24])
      8'h00:   r = ins[7:0];
      8'h01:   r = b;
      8'h02:   r = a + b;
      8'h03:   r = a - b;
      8'h04:   r = a & b;
      8'h05:   r = a | b;
      default: begin
        e.err = 1'b1;
        e.rdy = 1'b1;
        return e;
      end
    endcase
    e.lat   = (ins[31:24] == 8'h00) ? 4'd1 : 4'd3;
    if (ins[31:24] != 8'h00) begin
      e.rr1 = ins[10:8];
      e.rr2 = ins[2:0];
    end
    e.wreg  = ins[18:16];
    e.wdata = r;
    e.done  = 1'b1;
    e.rdy   = 1'b1;
    return e;
  endfunction

  // Issues one instruction from IDLE and records what the DUT did.
  task automatic run_op(input logic [31:0] ins, output obs_t o);
    o = '0;
    INSTR = ins;
    INSTR_VALID = 1'b1;
    @(posedge CLK); #1;
    INSTR_VALID = 1'b0;
    INSTR = $urandom;
    if (ERROR) begin
      o.err = 1'b1;
      o.rdy = INSTR_READY;
      o.we_after = WRITEENABLE | DONE;
      return;
    end
    if (!WRITEENABLE) begin
      o.rr1 = READREG1;
      o.rr2 = READREG2;
    end
    o.lat = 4'd1;
    while (!WRITEENABLE && o.lat < 4'd8) begin
      @(posedge CLK); #1;
      o.lat++;
    end
    o.wreg  = WRITEREG;
    o.wdata = WRITEDATA;
    o.done  = DONE;
    @(posedge CLK); #1;
    o.rdy = INSTR_READY;
    o.we_after = WRITEENABLE | DONE | ERROR;
  endtask

  task automatic test_reset;
    logic [26:0] got;
    got = {INSTR_READY, WRITEENABLE, DONE, ERROR,
           READREG1, READREG2, WRITEREG, WRITEDATA};
    tests++;
    if (got !== {1'b1, 3'b000, 9'd0, 8'h00}) begin
      fails++;
      $display("FAIL reset_values got=%h exp=%h", got,
               {1'b1, 3'b000, 9'd0, 8'h00});
    end
    RESET = 1'b0;
  endtask

  task automatic test_loadi;
    obs_t o, e;
    logic [31:0] ins;
    for (int r = 0; r < 8; r++) begin
      ins = $urandom;
      ins[31:24] = 8'h00;
      ins[18:16] = 3'(r);
      e = model(ins);
      run_op(ins, o);
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL loadi_r%0d got=%h exp=%h", r, o, e);
      end
      mdl[r] = e.wdata;
    end
    ins = 32'h0002005F;
    e = model(ins);
    run_op(ins, o);
    tests++;
    if (o !== e || o.wdata !== 8'd95 || o.wreg !== 3'd2) begin
      fails++;
      $display("FAIL loadi_95 got=%h exp=%h", o, e);
    end
    mdl[2] = e.wdata;
  endtask

  task automatic test_arith;
    logic [31:0] prog [8];
    logic [7:0]  lit  [8];
    logic        chk  [8];
    obs_t o, e;
    prog = '{32'h0001001C, 32'h02040102, 32'h00000000,
             32'h00030001, 32'h03050003, 32'h0006007F,
             32'h00070001, 32'h02000607};
    lit = '{8'h1C, 8'd123, 8'h00, 8'h01,
            8'hFF, 8'h7F, 8'h01, 8'h80};
    chk = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      e = model(prog[i]);
      run_op(prog[i], o);
      tests++;
      if (o !== e || (chk[i] && o.wdata !== lit[i])) begin
        fails++;
        $display("FAIL arith_%0d ins=%h got=%h exp=%h lit=%h",
                 i, prog[i], o, e, lit[i]);
      end
      mdl[prog[i][18:16]] = e.wdata;
    end
  endtask

  task automatic test_illegal;
    obs_t o, e;
    logic [31:0] ins;
    for (int i = 0; i < 4; i++) begin
      ins = $urandom;
      ins[31:24] = (i == 0) ? 8'h07 : 8'($urandom_range(6, 255));
      e = model(ins);
      run_op(ins, o);
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL illegal ins=%h got=%h exp=%h", ins, o, e);
      end
    end
  endtask

  task automatic test_random;
    obs_t o, e;
    logic [31:0] ins;
    int sel;
    for (int i = 0; i < 40; i++) begin
      ins = $urandom;
      sel = $urandom_range(0, 6);
      ins[31:24] = (sel < 6) ? 8'(sel) : 8'($urandom_range(6, 255));
      e = model(ins);
      run_op(ins, o);
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL random_%0d ins=%h got=%h exp=%h", i, ins, o, e);
      end
      if (!e.err) mdl[ins[18:16]] = e.wdata;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, b;
    obs_t e1, e2;
    logic [3:0] rdy_bits, we_bits;
    logic [7:0] wd1;
    int lat;
    a = 32'h02030102;
    b = 32'h02050304;
    e1 = model(a);
    mdl[3] = e1.wdata;
    e2 = model(b);
    wd1 = 8'h00;
    INSTR = a;
    INSTR_VALID = 1'b1;
    @(posedge CLK); #1;
    INSTR = b;
    for (int k = 0; k < 4; k++) begin
      rdy_bits[k] = INSTR_READY;
      we_bits[k] = WRITEENABLE;
      if (WRITEENABLE) wd1 = WRITEDATA;
      if (k < 3) begin
        @(posedge CLK); #1;
      end
    end
    tests++;
    if (rdy_bits !== 4'b1000 || we_bits !== 4'b0100) begin
      fails++;
      $display("FAIL b2b_spacing rdy=%b we=%b exp rdy=1000 we=0100",
               rdy_bits, we_bits);
    end
    tests++;
    if (wd1 !== e1.wdata) begin
      fails++;
      $display("FAIL b2b_first got=%h exp=%h", wd1, e1.wdata);
    end
    @(posedge CLK); #1;
    INSTR_VALID = 1'b0;
    lat = 1;
    while (!WRITEENABLE && lat < 8) begin
      @(posedge CLK); #1;
      lat++;
    end
    tests++;
    if (lat != 3 || WRITEDATA !== e2.wdata || WRITEREG !== 3'd5) begin
      fails++;
      $display("FAIL b2b_second lat=%0d wd=%h wr=%0d exp lat=3 wd=%h wr=5",
               lat, WRITEDATA, WRITEREG, e2.wdata);
    end
    mdl[5] = e2.wdata;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid;
    logic [26:0] got;
    logic seen;
    obs_t o, e;
    logic [31:0] ins;
    INSTR = 32'h02060101;
    INSTR_VALID = 1'b1;
    @(posedge CLK); #1;
    INSTR_VALID = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    #1;
    got = {INSTR_READY, WRITEENABLE, DONE, ERROR,
           READREG1, READREG2, WRITEREG, WRITEDATA};
    tests++;
    if (got !== {1'b1, 3'b000, 9'd0, 8'h00}) begin
      fails++;
      $display("FAIL reset_async got=%h exp=%h", got,
               {1'b1, 3'b000, 9'd0, 8'h00});
    end
    INSTR = 32'h00060033;
    INSTR_VALID = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      seen |= WRITEENABLE | DONE | ERROR | ~INSTR_READY;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold activity=%b exp=0", seen);
    end
    INSTR_VALID = 1'b0;
    RESET = 1'b0;
    ins = 32'h01000006;
    e = model(ins);
    run_op(ins, o);
    tests++;
    if (o !== e) begin
      fails++;
      $display("FAIL reset_recover got=%h exp=%h", o, e);
    end
    mdl[0] = e.wdata;
  endtask

  initial begin
    RESET = 1'b1;
    INSTR = 32'h0;
    INSTR_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    test_reset;
    test_loadi;
    test_arith;
    test_illegal;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_ctrl.md
REG_FILE_CTRL -- requirements
Module: reg_file_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-high, ports named CLK and RESET.
REQ-002 CLK  input  1  rising-edge clock shared with reg_file.
REQ-003 RESET  input  1  asynchronous active-high reset.
REQ-004 INSTR  input  32  instruction: [31:24] opcode, [18:16] dest reg, [10:8] src1 reg, [7:0] src2 reg ([2:0]) or immediate.
REQ-005 INSTR_VALID  input  1  INSTR holds a valid instruction.
REQ-006 INSTR_READY  output  1  block accepts INSTR this cycle.
REQ-007 REGOUT1, REGOUT2  input  8 each  read data returned by reg_file.
REQ-008 READREG1, READREG2  output  3 each  reg_file read addresses.
REQ-009 WRITEREG  output  3  reg_file write address.
REQ-010 WRITEDATA  output  8  reg_file write data.
REQ-011 WRITEENABLE  output  1  reg_file write strobe.
REQ-012 DONE  output  1  one-cycle pulse: instruction retired.
REQ-013 ERROR  output  1  one-cycle pulse: illegal opcode dropped.

Function
REQ-014 The block SHALL initiate reg_file transactions: it drives the reg_file address, data and write ports, but never its RESET.
REQ-015 The block SHALL implement states IDLE, READ, EXEC, WRITE; all outputs registered.
REQ-016 In IDLE, INSTR_READY=1; in all other states, INSTR_READY=0.
REQ-017 A handshake SHALL complete on a rising edge with INSTR_VALID=1 and INSTR_READY=1; INSTR is captured internally at that edge and ignored afterwards.
REQ-018 Opcodes: 0x00 loadi (dest=imm), 0x01 mov (dest=src2), 0x02 add (src1+src2), 0x03 sub (src1-src2), 0x04 and, 0x05 or.
REQ-019 On handshake: loadi -> WRITE; opcodes 0x01-0x05 -> READ; any other opcode -> IDLE with ERROR=1 for one cycle and no write.
REQ-020 In READ, READREG1=INSTR[10:8] and READREG2=INSTR[2:0]; next state EXEC.
REQ-021 In EXEC, the addresses SHALL be held; REGOUT1 and REGOUT2 are sampled at the EXEC->WRITE edge; the result is computed then.
REQ-022 Arithmetic SHALL be 8-bit two's complement with wrap-around and no carry/overflow flag: 0x7F+0x01=0x80; 0x00-0x01=0xFF.
REQ-023 In WRITE, the outputs SHALL be: WRITEENABLE=1 for exactly one cycle, WRITEREG=INSTR[18:16], WRITEDATA=result, DONE=1; next state IDLE.
REQ-024 Outside WRITE, WRITEENABLE=0 and DONE=0.
REQ-025 Latency from the handshake edge to the WRITEENABLE cycle SHALL be 3 cycles for register ops and 1 cycle for loadi; throughput is one instruction per 4 (reg op) or 2 (loadi) cycles.
REQ-026 Dest equal to a source is legal: the source value read in EXEC is used and the write occurs afterwards.
REQ-027 INSTR_VALID deasserting or INSTR changing after the handshake SHALL have no effect on the operation in flight.
REQ-028 Address bits outside the fields in REQ-004 SHALL be ignored.

Reset
REQ-029 RESET=1 SHALL immediately (asynchronously) force the following: state IDLE; INSTR_READY=1; WRITEENABLE=0, DONE=0, ERROR=0; READREG1, READREG2, WRITEREG = 0; WRITEDATA=0x00; internal instruction and result = 0.
REQ-030 Reset mid-operation SHALL abort the instruction with no write; the first handshake is possible on the first rising edge with RESET=0.
REQ-031 While RESET=1, the block SHALL accept no handshake.

Verification
REQ-032 loadi: INSTR=0x0002005F, valid one cycle -> WRITEENABLE high 1 cycle later, WRITEREG=2, WRITEDATA=95, DONE pulse.
REQ-033 add: reg1=28, reg2=95 preloaded; INSTR=0x02040102 -> READREG1=1, READREG2=2 in READ; WRITEREG=4, WRITEDATA=123 three cycles after the handshake.
REQ-034 sub wrap: reg0=0, reg3=1; INSTR=0x03050003 -> WRITEDATA=0xFF, WRITEREG=5; add 0x7F+0x01 -> 0x80.
REQ-035 Illegal opcode 0x07 -> ERROR pulse, WRITEENABLE stays 0, INSTR_READY=1 next cycle.
REQ-036 Back-to-back: INSTR_VALID held high with two add instructions -> the second is accepted only after the first's WRITE, exactly 4 cycles apart; INSTR_READY=0 in between.
REQ-037 RESET asserted during EXEC -> all outputs at reset values without waiting for a clock edge, no WRITEENABLE pulse, and the next valid instruction is executed normally.
